// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signal bundle of the refill/writeback arbiter.
// slave is the arbiter's view; master is the view of the caches plus memory.
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BEAT_W = 2
);
  // I-cache side
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_rvalid;
  logic              i_done;
  // D-cache side
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;
  logic              d_wnext;
  logic [BEAT_W-1:0] d_beat;
  logic              d_done;
  // Memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_rdata, i_rvalid, i_done, d_rdata, d_rvalid, d_wnext, d_beat, d_done,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_rdata, i_rvalid, i_done, d_rdata, d_rvalid, d_wnext, d_beat, d_done,
           mem_req, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache refill path and the D-cache refill/writeback path onto a
// single memory port, sequencing one fixed-length line burst per grant.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned BEAT_W     = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StIRd, StDRd, StDWr} state_e;

  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  // 1 when the D path owned the most recent grant; breaks ties in its disfavour.
  logic              last_d_q, last_d_d;

  logic in_burst;
  logic last_beat;

  assign in_burst  = (state_q != StIdle);
  assign last_beat = (beat_q == LastBeat);

  // State, beat counter, line base and fairness flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      base_q   <= '0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      base_q   <= base_d;
      last_d_q <= last_d_d;
    end
  end

  // Next-state logic: arbitration in idle, beat sequencing during a burst.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    base_d   = base_q;
    last_d_d = last_d_q;

    unique case (state_q)
      StIdle: begin
        // D wins when alone or when I was served last; mem_ack is ignored here.
        if (bus.d_req && (!bus.i_req || !last_d_q)) begin
          state_d  = bus.d_we ? StDWr : StDRd;
          base_d   = {bus.d_addr[ADDR_W-1:BEAT_W], {BEAT_W{1'b0}}};
          beat_d   = '0;
          last_d_d = 1'b1;
        end else if (bus.i_req) begin
          state_d  = StIRd;
          base_d   = {bus.i_addr[ADDR_W-1:BEAT_W], {BEAT_W{1'b0}}};
          beat_d   = '0;
          last_d_d = 1'b0;
        end
      end
      StIRd, StDRd, StDWr: begin
        if (bus.mem_ack) begin
          if (last_beat) begin
            state_d = StIdle;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory port and per-owner strobes; the non-owner's strobes stay low.
  always_comb begin
    bus.mem_req  = in_burst;
    bus.mem_we   = (state_q == StDWr);
    bus.mem_addr = in_burst ? {base_q[ADDR_W-1:BEAT_W], beat_q} : '0;
    bus.i_rvalid = (state_q == StIRd) && bus.mem_ack;
    bus.d_rvalid = (state_q == StDRd) && bus.mem_ack;
    bus.d_wnext  = (state_q == StDWr) && bus.mem_ack;
    bus.i_done   = bus.i_rvalid && last_beat;
    bus.d_done   = (bus.d_rvalid || bus.d_wnext) && last_beat;
    bus.d_beat   = beat_q;
    bus.busy     = in_burst;
  end

  // Data is passed straight through; only the strobes qualify it.
  assign bus.mem_wdata = bus.d_wdata;
  assign bus.i_rdata   = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues the expected beat events,
// a negedge monitor pops and compares whenever a strobe is presented.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;
  localparam int unsigned BW = 2;

  localparam logic [2:0] SI  = 3'b100;
  localparam logic [2:0] SDR = 3'b010;
  localparam logic [2:0] SDW = 3'b001;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .BEAT_W(BW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .BEAT_W(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic          req;
    logic [2:0]    strobe;
    logic [1:0]    done;
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] beat;
    logic [DW-1:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_act;
  ev_t mon_exp;
  int  checks = 0;
  int  errors = 0;

  function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
    return {2'b00, a} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] wdata_of(input logic [BW-1:0] b);
    return 32'hA500_0000 | {30'd0, b};
  endfunction

  // Memory model returns an address-derived word; D-cache supplies beat-derived data.
  assign bus.mem_rdata = rdata_of(bus.mem_addr);
  assign bus.d_wdata   = wdata_of(bus.d_beat);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_burst(input logic [2:0] who, input logic [AW-1:0] base, input int n);
    for (int b = 0; b < n; b++) begin
      ev_t e;
      e.req    = 1'b1;
      e.strobe = who;
      e.beat   = BW'(b);
      e.addr   = base | AW'(b);
      e.we     = (who == SDW);
      e.done   = (b == LW - 1) ? ((who == SI) ? 2'b10 : 2'b01) : 2'b00;
      e.data   = (who == SDW) ? wdata_of(e.beat) : rdata_of(e.addr);
      exp_q.push_back(e);
    end
  endtask

  // Waits for the owner's done, then drops its request on the sampling edge.
  task automatic wait_done(input bit is_d, input string name, output int cyc);
    cyc = 0;
    for (int k = 1; k <= 40 && cyc == 0; k++) begin
      @(negedge clk);
      if (is_d ? bus.d_done : bus.i_done) cyc = k;
    end
    if (cyc == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done, required done within 40 cycles", name);
    end
    @(posedge clk);
    #1;
    if (is_d) bus.d_req = 1'b0;
    else bus.i_req = 1'b0;
  endtask

  task automatic apply_reset();
    rst         = 1'b0;
    bus.i_req   = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.i_addr  = '0;
    bus.d_addr  = '0;
    bus.mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst && (bus.i_rvalid || bus.d_rvalid || bus.d_wnext || bus.i_done || bus.d_done)) begin
      mon_act.req    = bus.mem_req;
      mon_act.strobe = {bus.i_rvalid, bus.d_rvalid, bus.d_wnext};
      mon_act.done   = {bus.i_done, bus.d_done};
      mon_act.addr   = bus.mem_addr;
      mon_act.we     = bus.mem_we;
      mon_act.beat   = bus.d_beat;
      mon_act.data   = bus.d_wnext ? bus.mem_wdata : (bus.i_rvalid ? bus.i_rdata : bus.d_rdata);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got %h, required no event", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL beat_event: got %h, required %h", mon_act, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int acks;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    apply_reset();
    // Reset state, observed while reset is still asserted.
    rst = 1'b0;
    #1;
    check("reset_ctrl", {bus.busy, bus.mem_req, bus.mem_we, bus.d_beat}, 64'h0);
    check("reset_addr", bus.mem_addr, 64'h0);
    check("reset_strobes", {bus.i_rvalid, bus.d_rvalid, bus.d_wnext, bus.i_done, bus.d_done},
          64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Lone I refill.
    push_burst(SI, 30'h10, LW);
    bus.i_addr = 30'h12;
    bus.i_req  = 1'b1;
    wait_done(1'b0, "t1_i", cyc);
    check("t1_i_done_latency", cyc, 64'd5);

    // Simultaneous requests after reset: D first, then I.
    apply_reset();
    push_burst(SDR, 30'h44, LW);
    push_burst(SI, 30'h08, LW);
    bus.d_we   = 1'b0;
    bus.d_addr = 30'h44;
    bus.i_addr = 30'h0B;
    bus.d_req  = 1'b1;
    bus.i_req  = 1'b1;
    wait_done(1'b1, "t2_d", cyc);
    check("t2_d_done_latency", cyc, 64'd5);
    wait_done(1'b0, "t2_i", cyc);
    check("t2_i_after_d", cyc, 64'd5);

    // D writeback with wait states.
    push_burst(SDW, 30'h20, LW);
    bus.mem_ack = 1'b0;
    bus.d_we    = 1'b1;
    bus.d_addr  = 30'h20;
    bus.d_req   = 1'b1;
    @(negedge clk);
    check("t3_grant_cycle_quiet", {bus.busy, bus.mem_req}, 64'h0);
    acks = 0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      bus.mem_ack = pat[k][0];
      @(negedge clk);
      check("t3_addr_hold", bus.mem_addr, 64'(30'h20 + acks));
      check("t3_we_req", {bus.mem_req, bus.mem_we}, 64'h3);
      check("t3_wnext", bus.d_wnext, 64'(pat[k]));
      check("t3_done", bus.d_done, 64'(k == 6));
      acks += pat[k];
    end
    @(posedge clk);
    #1;
    bus.d_req   = 1'b0;
    bus.mem_ack = 1'b1;

    // Both again after a D burst: I wins this time.
    push_burst(SI, 30'h1C, LW);
    push_burst(SDR, 30'h30, LW);
    bus.d_we   = 1'b0;
    bus.d_addr = 30'h31;
    bus.i_addr = 30'h1C;
    bus.d_req  = 1'b1;
    bus.i_req  = 1'b1;
    wait_done(1'b0, "t2b_i", cyc);
    wait_done(1'b1, "t2b_d", cyc);

    // Late D request during the second I beat: no preemption.
    push_burst(SI, 30'h40, LW);
    push_burst(SDR, 30'h50, LW);
    bus.i_addr = 30'h43;
    bus.i_req  = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.d_we   = 1'b0;
    bus.d_addr = 30'h52;
    bus.d_req  = 1'b1;
    wait_done(1'b0, "t4_i", cyc);
    check("t4_i_undisturbed", cyc, 64'd3);
    wait_done(1'b1, "t4_d", cyc);

    // Reset during beat 2 of a D read.
    push_burst(SDR, 30'h64, 2);
    bus.d_we   = 1'b0;
    bus.d_addr = 30'h66;
    bus.d_req  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    rst         = 1'b0;
    #1;
    check("t5_async_drop", {bus.mem_req, bus.busy, bus.d_beat, bus.d_done}, 64'h0);
    check("t5_beats_consumed", exp_q.size(), 64'd0);
    @(negedge clk);
    push_burst(SDR, 30'h64, LW);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    bus.mem_ack = 1'b1;
    wait_done(1'b1, "t5_restart", cyc);
    check("t5_restart_latency", cyc, 64'd5);

    // Spurious ack while idle.
    bus.mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_idle_quiet", {bus.busy, bus.mem_req, bus.i_rvalid, bus.d_rvalid, bus.d_wnext,
                              bus.i_done, bus.d_done}, 64'h0);
    end

    check("queue_drained", exp_q.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one main-memory port between the instruction-cache refill path and the data-cache refill/writeback path of the 5-stage pipeline.
- A cache miss (ins hit or data hit low) stalls the pipeline while that cache's refill is in progress.
- The block grants one requester at a time and sequences a fixed-length line burst to memory with a beat counter.
- It returns done pulses that let the cache assert hit and release the pipeline stall.

Parameters:
- ADDR_W, 30, word-address width (matches the 30-bit PC).
- DATA_W, 32, data word width.
- LINE_WORDS, 4, words per cache line; power of 2, at least 2.
- BEAT_W, 2, log2(LINE_WORDS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  I-cache line read request; held until i_done.
- i_addr  in  ADDR_W  I-cache miss word address; low BEAT_W bits are ignored.
- i_rdata  out  DATA_W  refill word (mem_rdata passthrough).
- i_rvalid  out  1  i_rdata valid this cycle.
- i_done  out  1  one-cycle pulse on the last I beat.
- d_req  in  1  D-cache line request; held until d_done.
- d_we  in  1  1 = line writeback, 0 = line read; sampled at grant.
- d_addr  in  ADDR_W  D-cache line address; low BEAT_W bits are ignored.
- d_wdata  in  DATA_W  writeback word for the current d_beat.
- d_rdata  out  DATA_W  refill word (mem_rdata passthrough).
- d_rvalid  out  1  d_rdata valid this cycle (read bursts only).
- d_wnext  out  1  current write word was accepted; D-cache advances.
- d_beat  out  BEAT_W  current beat index.
- d_done  out  1  one-cycle pulse on the last D beat.
- mem_req  out  1  memory access request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  equals d_wdata.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  beat complete this cycle.
- busy  out  1  FSM not in IDLE.

Behaviour:
- **FSM states:** IDLE, I_RD, D_RD, D_WR. All state registers reset asynchronously on rst=0.
- **Reset values:**
  - state=IDLE, beat=0, base=0, last_srv=I.
  - All outputs 0: mem_req, mem_we, mem_addr, done/valid/wnext, busy.
- **Arbitration (IDLE only):**
  - d_req alone goes to D_RD or D_WR per d_we.
  - i_req alone goes to I_RD.
  - Both asserted: grant the requester not in last_srv; after reset D wins first.
  - last_srv updates at grant.
  - At grant, register base = addr with the low BEAT_W bits cleared, and beat=0.
  - The grant cycle itself drives no memory activity (1-cycle arbitration latency).
- **Burst states:**
  - mem_req=1 continuously; mem_we=1 only in D_WR.
  - mem_addr = base | beat, driven from registers.
  - A cycle with mem_ack=1 completes a beat. In that cycle assert i_rvalid (I_RD), d_rvalid (D_RD) or d_wnext (D_WR), then increment beat.
  - mem_ack=0 inserts wait cycles; all outputs hold.
  - A beat that is acked with beat == LINE_WORDS-1 pulses the done of the owner in that same cycle. On that edge the FSM returns to IDLE and beat resets to 0.
  - The beat counter never wraps inside a burst.
- **Requester rule:**
  - Deassert req at the edge where done is sampled high.
  - Requests are never preempted mid-burst.
  - A request arriving during a burst waits in IDLE arbitration.
  - The non-owner's outputs stay 0.
- **d_beat** equals beat in every state (0 in IDLE).
- **Passthrough:** d_wdata is passed combinationally to mem_wdata. mem_rdata is passed to both rdata outputs; only the valid strobes qualify it.
- **Ignored inputs:** mem_ack in IDLE is ignored. Changes to addr/d_we after grant are ignored.
- **Reset mid-burst:** mem_req drops immediately (async) and no done pulse is issued. The requester must reissue its request.
- **Minimum burst latency:** LINE_WORDS+1 cycles from a req seen in IDLE to done.

Test Plan:
1. **Lone I refill.** i_req=1 with i_addr=0x00000012, memory acks every cycle.
   - mem_addr sequence 0x10, 0x11, 0x12, 0x13.
   - i_rvalid high for 4 cycles.
   - i_done pulses 5 cycles after the req is sampled.
   - mem_we=0 throughout.
2. **Simultaneous requests after reset.** i_req and d_req both high, d_we=0.
   - D served first.
   - The I burst starts in the cycle after d_done, once d_req has dropped.
   - Then raise both again: I is served first (alternation).
3. **D writeback with waits.** d_we=1, d_addr=0x20, mem_ack pattern 1,0,0,1,1,0,1.
   - mem_we=1 throughout.
   - d_wnext pulses exactly on the 4 ack cycles.
   - mem_addr holds across the wait cycles.
   - d_beat steps 0→3.
   - d_done on the 7th burst cycle.
4. **Late request, no preemption.** d_req rises during the 2nd beat of an I burst.
   - The I burst completes undisturbed.
   - The D grant follows in IDLE; d_rvalid stays 0 until the D burst begins.
5. **Reset mid-burst.** Assert rst=0 during beat 2 of a D read.
   - mem_req, busy and d_beat go to 0 asynchronously; no d_done.
   - After release, a held d_req restarts from beat 0 at base.
6. **Spurious ack.** Drive mem_ack=1 while idle with no requests.
   - No valid, wnext or done pulses; busy stays 0.
